// File: rtl/lfsr12_pkg.sv
// lfsr12_pkg: shared types and the 12-bit Galois LFSR step function.
// Used by the checker here and by the pattern generator on the far end.
package lfsr12_pkg;

  localparam int LFSR_W = 12;

  typedef enum logic [1:0] {
    HUNT,
    TRAIN,
    LOCKED
  } lfsr12_state_e;

  // Galois step: shift left, feedback from bit 11 into bits 0 and 4..10.
  function automatic logic [LFSR_W-1:0] lfsr12_step(
    input logic [LFSR_W-1:0] s
  );
    logic [LFSR_W-1:0] n;
    n[0]   = s[11];
    n[3:1] = s[2:0];
    for (int k = 4; k <= 10; k++) begin
      n[k] = s[k-1] ^ s[11];
    end
    n[11]  = s[10];
    return n;
  endfunction

endpackage

// File: rtl/lfsr12_checker.sv
// lfsr12_checker: self-synchronising receive checker for the 12-bit LFSR
// test pattern; hunts, trains on LOCK_CNT matches, then flywheels.
// Ports: clk, rst (sync, active-high), in_valid, in_data[11:0], clear
//   -> locked, err_pulse, sync_loss, err_count[ERR_W-1:0] (all registered).
module lfsr12_checker
  import lfsr12_pkg::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int MISS_LIMIT = 4,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic              sync_loss,
  output logic [ERR_W-1:0]  err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int XW = $clog2(MISS_LIMIT + 1);

  localparam logic [MW-1:0]    M_ONE     = MW'(1);
  localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [XW-1:0]    X_ONE     = XW'(1);
  localparam logic [XW-1:0]    MISS_LAST = XW'(MISS_LIMIT - 1);
  localparam logic [ERR_W-1:0] E_ONE     = ERR_W'(1);

  lfsr12_state_e     state_q, state_d;
  logic [LFSR_W-1:0] pred_q, pred_d;
  logic [MW-1:0]     match_q, match_d;
  logic [XW-1:0]     miss_q, miss_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              locked_q, locked_d;
  logic              ep_q, ep_d;
  logic              sl_q, sl_d;

  logic hit;
  logic nz;

  assign hit = (in_data == pred_q);
  assign nz  = |in_data;

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = err_q;
    ep_d    = 1'b0;
    sl_d    = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          // All-zero is the lock-up state, never a usable seed.
          if (nz) begin
            pred_d  = lfsr12_step(in_data);
            match_d = '0;
            state_d = TRAIN;
          end
        end
        TRAIN: begin
          if (hit) begin
            pred_d  = lfsr12_step(pred_q);
            match_d = match_q + M_ONE;
            if (match_q == LOCK_LAST) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (nz) begin
            pred_d  = lfsr12_step(in_data);
            match_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: the predictor never reseeds from data once locked.
          pred_d = lfsr12_step(pred_q);
          if (hit) begin
            miss_d = '0;
          end else begin
            ep_d = 1'b1;
            if (err_q != '1) begin
              err_d = err_q + E_ONE;
            end
            if (miss_q == MISS_LAST) begin
              state_d = HUNT;
              miss_d  = '0;
              sl_d    = 1'b1;
            end else begin
              miss_d = miss_q + X_ONE;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end

    // A clear that lands on a counted error keeps that one error.
    if (clear) begin
      err_d = ep_d ? E_ONE : '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      pred_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      err_q    <= '0;
      locked_q <= 1'b0;
      ep_q     <= 1'b0;
      sl_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      ep_q     <= ep_d;
      sl_q     <= sl_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = ep_q;
  assign sync_loss = sl_q;
  assign err_count = err_q;

endmodule

// File: doc/lfsr12_checker.md
# lfsr12_checker

Receive-side checker for the 12-bit Galois LFSR test pattern used on the video verification path. It accepts one 12-bit word per valid beat and self-synchronises by seeding a local predictor from the incoming stream. Once locked, it flywheels the predictor, flags and counts mismatching words, and drops lock after a run of consecutive misses. It sits at the sink end of the test link, opposite the pattern generator, and feeds status and error counts to the verification/reporting logic.

## Interface
- LOCK_CNT, 8: consecutive correct predictions required to declare lock (≥1)
- MISS_LIMIT, 4: consecutive mismatches while locked that force loss of sync (≥1)
- ERR_W, 16: width of the saturating error counter
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_data carries a pattern word this cycle
- in_data  in  12  received pattern word
- clear  in  1  synchronous clear of err_count
- locked  out  1  predictor in sync with stream
- err_pulse  out  1  one-cycle pulse per mismatching word while locked
- sync_loss  out  1  one-cycle pulse when lock is dropped
- err_count  out  ERR_W  saturating count of mismatching words while locked

## Operation
- Step function S(s), shared with the generator: n[0]=s[11]; n[3:1]=s[2:0]; n[k]=s[k-1]^s[11] for k=4..10; n[11]=s[10]. Examples: S(001)=002, S(400)=800, S(800)=7F1. All-zero is the lock-up state and never a valid seed.
- States: HUNT, TRAIN, LOCKED. Internal: pred[11:0], match_cnt, miss_cnt.
- Cycles with in_valid=0: no state, counter or pred change; pulses low.
- HUNT: valid & in_data≠0 → pred←S(in_data), match_cnt←0, go TRAIN. valid & in_data=0 → stay.
- TRAIN: valid & in_data==pred → pred←S(pred), match_cnt+1; when this is match number LOCK_CNT → go LOCKED, locked←1, miss_cnt←0. Mismatch with in_data≠0 → reseed pred←S(in_data), match_cnt←0, stay TRAIN. Mismatch with in_data=0 → go HUNT.
- LOCKED: every valid word advances pred←S(pred) (flywheel; never reseeded from data). Match → miss_cnt←0. Mismatch → err_pulse, err_count+1 (saturates at all-ones), miss_cnt+1; on the MISS_LIMIT-th consecutive miss → go HUNT, locked←0, sync_loss pulse.
- Errors are counted only in LOCKED. Mismatches in TRAIN are not errors.
- clear: err_count←0. If clear coincides with a counted error, err_count←1. clear does not affect state or lock.
- Reset, including mid-lock: state HUNT, pred=0, all counters 0, locked=0, err_pulse=0, sync_loss=0, err_count=0.

## Timing
- All outputs registered. A word sampled at edge N affects locked, err_pulse, sync_loss and err_count after edge N, i.e. visible in cycle N+1.
- Continuous valid, clean stream: locked rises one cycle after word LOCK_CNT+1 (the seed word plus LOCK_CNT matches).
- err_pulse and the final-miss sync_loss are asserted in the same cycle. locked falls in that same cycle.
- Throughput: one word per clock, no back-pressure.

## Structure
- Package lfsr12_pkg: LFSR_W=12 constant, function lfsr12_step (S above), state enum {HUNT, TRAIN, LOCKED}. The generator side reuses the same step function.
- Single module. No sub-module is needed; the predictor is one register plus lfsr12_step.

## Test plan
- Reset; drive the generator stream seeded 001 (001, 002, 004, …) with continuous valid → locked=1 one cycle after the 9th word; err_count stays 0.
- While locked, XOR bit 0 into one word → one err_pulse, err_count=1, locked stays 1; the following uncorrupted word matches and causes no further pulse.
- While locked, corrupt 4 consecutive words → err_count=4; sync_loss and locked=0 in the cycle after the 4th bad word. Resuming a clean stream → relock after 9 valid words.
- In HUNT, drive in_data=000 for 10 valid cycles → state stays HUNT, locked=0. Then drive 800, 7F1, … → lock is acquired normally.
- Clean stream with in_valid deasserted on random cycles (about 50%) → lock is acquired after 9 valid words, with no err_pulse.
- ERR_W=4, 20 isolated errors while locked → err_count saturates at 15. clear in the same cycle as an error → err_count=1. rst mid-lock → all outputs 0, state HUNT on the next cycle.
